// File: rtl/imm_gen_pipe.sv
// Registered RV immediate generator with a two-entry valid/ready skid.
// Decodes the immediate format from imm_sel, or from the opcode when
// AUTO_DECODE=1. Sign-extends the result to XLEN bits and carries a
// sideband tag through in strict FIFO order.
//
// state | meaning
// ------+--------------------------------------------------------------
// EMPTY | nothing held; output register idle, in_ready=1
// ONE   | output register holds the oldest entry, skid empty, in_ready=1
// TWO   | output register and skid both full, in_ready=0
module imm_gen_pipe #(
    parameter int XLEN        = 32,
    parameter bit AUTO_DECODE = 1'b0,
    parameter int TAG_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal
);

    localparam logic [2:0] FMT_I   = 3'd0;
    localparam logic [2:0] FMT_S   = 3'd1;
    localparam logic [2:0] FMT_B   = 3'd2;
    localparam logic [2:0] FMT_U   = 3'd3;
    localparam logic [2:0] FMT_J   = 3'd4;
    localparam logic [2:0] FMT_BAD = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        fmt;
    logic [31:0]       raw;
    logic              new_ill;
    logic [XLEN-1:0]   new_imm;
    logic [XLEN-1:0]   skid_imm;
    logic [TAG_W-1:0]  skid_tag;
    logic              skid_ill;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Select the immediate format: explicit select, or opcode decode.
    always_comb begin
        fmt = imm_sel;
        if (AUTO_DECODE) begin
            case (instr[6:0])
                7'b0010011, 7'b0000011,
                7'b1100111, 7'b1110011: fmt = FMT_I;
                7'b0100011:             fmt = FMT_S;
                7'b1100011:             fmt = FMT_B;
                7'b0110111, 7'b0010111: fmt = FMT_U;
                7'b1101111:             fmt = FMT_J;
                default:                fmt = FMT_BAD;
            endcase
        end
    end

    // Assemble the 32-bit sign-extended immediate; unknown formats give zero.
    always_comb begin
        raw     = '0;
        new_ill = 1'b0;
        case (fmt)
            FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            FMT_U:   raw = {instr[31:12], 12'b0};
            FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: new_ill = 1'b1;
        endcase
    end

    // Widen to XLEN; every format's sign lives in instr[31], now raw[31].
    if (XLEN == 32) begin : g_x32
        assign new_imm = raw;
    end else begin : g_xwide
        assign new_imm = {{(XLEN-32){raw[31]}}, raw};
    end

    // Occupancy FSM with registered handshake outputs, output register and skid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            imm       <= '0;
            out_tag   <= '0;
            illegal   <= 1'b0;
            skid_imm  <= '0;
            skid_tag  <= '0;
            skid_ill  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        imm       <= new_imm;
                        out_tag   <= in_tag;
                        illegal   <= new_ill;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_imm <= new_imm;
                        skid_tag <= in_tag;
                        skid_ill <= new_ill;
                        in_ready <= 1'b0;
                        state    <= TWO;
                    end else if (in_fire && out_fire) begin
                        imm     <= new_imm;
                        out_tag <= in_tag;
                        illegal <= new_ill;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        imm      <= skid_imm;
                        out_tag  <= skid_tag;
                        illegal  <= skid_ill;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
